// File: rtl/game_sequencer.sv
// game_sequencer: IDLE/PLAY/DEAD sequencer for a one-pipe scrolling game.
// The bird is steered by a pitch-derived target level, or falls when there is
// no valid pitch. All motion happens only on frame ticks while in PLAY.
module game_sequencer #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int PIPE_WIDTH    = 50,
  parameter int PIPE_GAP      = 100,
  parameter int BIRD_X        = 500,
  parameter int BIRD_SIZE     = 20,
  parameter int PIPE_SPEED    = 4,
  parameter int GAP_MIN       = 40,
  parameter int DEAD_HOLD     = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_button,
  input  logic       pitch_valid,
  input  logic [9:0] pitch_level,
  output logic [9:0] bird_y,
  output logic [9:0] pipe_x,
  output logic [9:0] pipe_y_top,
  output logic [9:0] pipe_y_bot,
  output logic [7:0] score,
  output logic       collision_out,
  output logic [1:0] state
);

  typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, DEAD = 2'b10} st_t;

  // 11-bit constants so sums like pipe_x + PIPE_WIDTH never wrap
  localparam logic [10:0] FLOOR   = 11'(SCREEN_HEIGHT - BIRD_SIZE);
  localparam logic [10:0] BIRD_Y0 = 11'd230;
  localparam logic [10:0] PIPE_X0 = 11'(SCREEN_WIDTH);
  localparam logic [10:0] TOP0    = 11'd190;
  localparam logic [10:0] BOT0    = 11'(190 + PIPE_GAP);
  localparam logic [10:0] BX_LO   = 11'(BIRD_X);
  localparam logic [10:0] BX_HI   = 11'(BIRD_X + BIRD_SIZE);
  localparam logic [10:0] PW      = 11'(PIPE_WIDTH);
  localparam logic [10:0] BS      = 11'(BIRD_SIZE);
  localparam logic [10:0] SPD     = 11'(PIPE_SPEED);
  localparam logic [10:0] GMIN    = 11'(GAP_MIN);
  localparam logic [10:0] GAP     = 11'(PIPE_GAP);
  localparam logic [10:0] STEP    = 11'd4;
  localparam logic [10:0] FALL    = 11'd2;
  localparam int          DW      = $clog2(DEAD_HOLD + 1);
  localparam logic [DW-1:0] DLAST = DW'(DEAD_HOLD - 1);

  st_t           st;
  logic          btn_q;
  logic [7:0]    lfsr;
  logic [DW-1:0] dead_cnt;

  logic [10:0] by, px, pt, pb, tgt;
  logic [10:0] by_nxt, px_nxt, pt_nxt, pb_nxt;
  logic        hit_x, hit_y, collide, wrap, start_edge, lfsr_fb;
  logic        unused;

  assign start_edge = start_button & ~btn_q;
  assign lfsr_fb    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign state      = st;

  // Collision test and next-position arithmetic on the registered positions
  always_comb begin
    by = {1'b0, bird_y};
    px = {1'b0, pipe_x};
    pt = {1'b0, pipe_y_top};
    pb = {1'b0, pipe_y_bot};

    hit_x   = (px < BX_HI) && (BX_LO < px + PW);
    hit_y   = (by < pt) || (by + BS > pb);
    collide = (hit_x && hit_y) || (by == FLOOR);

    // the pitch target is clamped so the bird can never be steered below the floor
    tgt = ({1'b0, pitch_level} > FLOOR) ? FLOOR : {1'b0, pitch_level};
    if (!pitch_valid)
      by_nxt = (by + FALL > FLOOR) ? FLOOR : by + FALL;
    else if (tgt > by)
      by_nxt = (tgt - by > STEP) ? by + STEP : tgt;
    else
      by_nxt = (by - tgt > STEP) ? by - STEP : tgt;

    wrap   = (px < SPD);
    px_nxt = wrap ? PIPE_X0 : px - SPD;
    pt_nxt = GMIN + {3'b000, lfsr};
    pb_nxt = pt_nxt + GAP;
  end

  assign unused = ^{by_nxt[10], px_nxt[10], pt_nxt[10], pb_nxt[10]};

  // Free-running gap generator and start-button edge register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr  <= 8'hA5;
      btn_q <= 1'b0;
    end else begin
      lfsr  <= {lfsr[6:0], lfsr_fb};
      btn_q <= start_button;
    end
  end

  // Game FSM with all positions, score and collision flag registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st            <= IDLE;
      bird_y        <= BIRD_Y0[9:0];
      pipe_x        <= PIPE_X0[9:0];
      pipe_y_top    <= TOP0[9:0];
      pipe_y_bot    <= BOT0[9:0];
      score         <= 8'd0;
      collision_out <= 1'b0;
      dead_cnt      <= '0;
    end else begin
      case (st)
        IDLE: begin
          collision_out <= 1'b0;
          // a tick on the same clock as the start edge does not move anything
          if (start_edge) begin
            st     <= PLAY;
            bird_y <= BIRD_Y0[9:0];
            pipe_x <= PIPE_X0[9:0];
            score  <= 8'd0;
          end
        end
        PLAY: begin
          if (collide) begin
            st            <= DEAD;
            collision_out <= 1'b1;
            dead_cnt      <= '0;
          end else if (tick) begin
            bird_y <= by_nxt[9:0];
            pipe_x <= px_nxt[9:0];
            if (wrap) begin
              pipe_y_top <= pt_nxt[9:0];
              pipe_y_bot <= pb_nxt[9:0];
              if (score != 8'hFF) score <= score + 8'd1;
            end
          end
        end
        DEAD: begin
          if (tick) begin
            if (dead_cnt == DLAST) begin
              st            <= IDLE;
              collision_out <= 1'b0;
              dead_cnt      <= '0;
            end else begin
              dead_cnt <= dead_cnt + 1'b1;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed game scenarios followed by randomized play,
// every cycle compared against a behavioural model of the game rules.
module tb_game_sequencer;
  localparam int W = 640, H = 480, PW = 50, GAP = 100, BX = 500, BS = 20;
  localparam int SPD = 4, GMIN = 40, HOLD = 60, FLOOR = H - BS;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       start_button = 1'b0;
  logic       pitch_valid = 1'b0;
  logic [9:0] pitch_level = '0;
  logic [9:0] bird_y, pipe_x, pipe_y_top, pipe_y_bot;
  logic [7:0] score;
  logic       collision_out;
  logic [1:0] state;

  int n_chk = 0;
  int n_err = 0;

  // game model state
  int m_st, m_by, m_px, m_pt, m_pb, m_sc, m_col, m_lf, m_dt, m_btn;

  always #5 clk = ~clk;

  game_sequencer dut (
    .clk(clk), .reset(reset), .tick(tick), .start_button(start_button),
    .pitch_valid(pitch_valid), .pitch_level(pitch_level),
    .bird_y(bird_y), .pipe_x(pipe_x), .pipe_y_top(pipe_y_top), .pipe_y_bot(pipe_y_bot),
    .score(score), .collision_out(collision_out), .state(state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_by = 230; m_px = W; m_pt = 190; m_pb = 290;
    m_sc = 0; m_col = 0; m_lf = 8'hA5; m_dt = 0; m_btn = 0;
  endtask

  function automatic bit m_hit();
    bit h;
    h = (m_px < BX + BS) && (m_px + PW > BX);
    return (h && (m_by < m_pt || m_by + BS > m_pb)) || (m_by == FLOOR);
  endfunction

  // one clock of game rules, applied with the inputs present at the edge
  task automatic model_clk();
    bit edge_s;
    int tgt, d;
    edge_s = start_button && !m_btn;
    case (m_st)
      0: if (edge_s) begin m_st = 1; m_by = 230; m_px = W; m_sc = 0; end
      1: if (m_hit()) begin
           m_st = 2; m_col = 1; m_dt = 0;
         end else if (tick) begin
           if (m_px >= SPD) m_px -= SPD;
           else begin
             m_px = W; m_pt = GMIN + m_lf; m_pb = m_pt + GAP;
             if (m_sc < 255) m_sc++;
           end
           if (pitch_valid) begin
             tgt = (pitch_level > FLOOR) ? FLOOR : int'(pitch_level);
             d = tgt - m_by;
             if (d > 4) d = 4;
             if (d < -4) d = -4;
             m_by += d;
           end else begin
             m_by = (m_by + 2 > FLOOR) ? FLOOR : m_by + 2;
           end
         end
      default: if (tick) begin
           m_dt++;
           if (m_dt == HOLD) begin m_st = 0; m_col = 0; m_dt = 0; end
         end
    endcase
    m_btn = start_button;
    m_lf = ((m_lf << 1) | ($countones(m_lf & 8'hB8) & 1)) & 8'hFF;
  endtask

  task automatic check_all();
    chk("state", 32'(state), 32'(m_st));
    chk("bird_y", 32'(bird_y), 32'(m_by));
    chk("pipe_x", 32'(pipe_x), 32'(m_px));
    chk("pipe_y_top", 32'(pipe_y_top), 32'(m_pt));
    chk("pipe_y_bot", 32'(pipe_y_bot), 32'(m_pb));
    chk("score", 32'(score), 32'(m_sc));
    chk("collision", 32'(collision_out), 32'(m_col));
  endtask

  task automatic cyc();
    @(posedge clk);
    if (reset) model_clk(); else model_reset();
    #1;
    check_all();
  endtask

  task automatic rst_pulse();
    reset = 1'b0;
    #2;
    model_reset();
    check_all();
    cyc();
    reset = 1'b1;
  endtask

  initial begin
    int sc0;
    // power-on reset, checked before any clock edge
    #1 reset = 1'b0;
    #1 model_reset();
    check_all();
    cyc();
    cyc();
    reset = 1'b1;

    // one-clock start pulse enters PLAY on the next clock
    start_button = 1'b1;
    cyc();
    chk("start_play", 32'(state), 32'd1);
    start_button = 1'b0;
    pitch_valid = 1'b1; pitch_level = 10'd230; tick = 1'b1;
    repeat (3) cyc();
    chk("pipe_after3", 32'(pipe_x), 32'd628);

    // steer toward 200: 4 px steps, exact landing, then hold
    pitch_level = 10'd200;
    repeat (8) cyc();
    chk("bird_land", 32'(bird_y), 32'd200);
    repeat (2) cyc();
    chk("bird_hold", 32'(bird_y), 32'd200);

    // bird high above the 190 gap top meets the pipe and dies
    pitch_level = 10'd100;
    for (int i = 0; i < 200 && m_st != 2; i++) cyc();
    chk("pipe_dead", 32'(state), 32'd2);
    chk("dead_flag", 32'(collision_out), 32'd1);

    // start held through DEAD: returns to IDLE after HOLD ticks and stays there
    start_button = 1'b1;
    for (int i = 0; i < HOLD; i++) cyc();
    chk("dead_to_idle", 32'(state), 32'd0);
    chk("score_kept", 32'(score), 32'd0);
    repeat (5) cyc();
    chk("held_no_start", 32'(state), 32'd0);
    start_button = 1'b0;
    cyc();
    start_button = 1'b1;
    cyc();
    chk("repress_start", 32'(state), 32'd1);
    start_button = 1'b0;

    // second game: ride the gap past the pipe, then fall to the floor through a wrap
    pitch_level = 10'(m_pt + 40);
    repeat (50) cyc();
    pitch_valid = 1'b0;
    sc0 = m_sc;
    for (int i = 0; i < 300 && m_by != FLOOR; i++) begin
      cyc();
      if (m_sc != sc0) begin
        sc0 = m_sc;
        chk("wrap_x", 32'(pipe_x), 32'(W));
        chk("wrap_gap", 32'(pipe_y_bot - pipe_y_top), 32'(GAP));
        chk("wrap_top_rng", 32'(pipe_y_top >= 10'(GMIN) && pipe_y_top <= 10'(GMIN + 255)), 32'd1);
        chk("wrap_score", 32'(score), 32'd1);
      end
    end
    chk("floor_y", 32'(bird_y), 32'(FLOOR));
    chk("floor_still_play", 32'(state), 32'd1);
    tick = 1'b0;
    cyc();
    chk("floor_dead", 32'(state), 32'd2);
    chk("floor_flag", 32'(collision_out), 32'd1);

    // reset in the middle of DEAD
    tick = 1'b1;
    repeat (10) cyc();
    rst_pulse();
    chk("mid_rst_state", 32'(state), 32'd0);

    // randomized play
    for (int i = 0; i < 8000; i++) begin
      tick = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 15) == 0) start_button = ~start_button;
      pitch_valid = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) < 8) pitch_level = 10'(m_pt + $urandom_range(0, 80));
      else pitch_level = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 1999) == 0) rst_pulse();
      else cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
